// File: rtl/sobel_window.sv
// Read end of the 3-tap line buffer: builds a 3x3 window from the row taps and
// produces the saturated Sobel gradient magnitude through a 3-stage pipeline.
module sobel_window #(
    parameter int WIDTH    = 12,
    parameter int LINE_LEN = 640,
    parameter int SHIFT    = 2,
    parameter int THRESH   = 512
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             iValid,
    input  logic             iEdge,
    input  logic [WIDTH-1:0] row_top,
    input  logic [WIDTH-1:0] row_mid,
    input  logic [WIDTH-1:0] row_bot,
    output logic [WIDTH-1:0] oData,
    output logic             oBin,
    output logic             oValid,
    output logic             oEdge
);

    localparam int COL_W = (LINE_LEN > 2) ? $clog2(LINE_LEN) : 2;
    localparam int GW    = WIDTH + 3;
    localparam int MW    = WIDTH + 4;
    localparam logic [MW-1:0] SAT = MW'((1 << WIDTH) - 1);

    // Index 0 holds the newest column, index 2 the oldest.
    logic [2:0][WIDTH-1:0] top_w;
    logic [2:0][WIDTH-1:0] mid_w;
    logic [2:0][WIDTH-1:0] bot_w;
    logic [COL_W-1:0]      col;
    logic                  v1;
    logic                  e1;
    logic                  v2;
    logic                  e2;
    logic signed [GW-1:0]  gx_r;
    logic signed [GW-1:0]  gy_r;
    logic signed [GW-1:0]  gx_next;
    logic signed [GW-1:0]  gy_next;
    logic [GW-1:0]         abs_gx;
    logic [GW-1:0]         abs_gy;
    logic [MW-1:0]         mag;
    logic [MW-1:0]         shifted;
    logic [WIDTH-1:0]      pix_next;
    logic                  col_border;
    logic                  col_last;

    assign col_border = (col == '0) || (col == COL_W'(1));
    assign col_last   = (col == COL_W'(LINE_LEN - 1));

    function automatic logic signed [GW-1:0] ext(input logic [WIDTH-1:0] p);
        return $signed({3'b000, p});
    endfunction

    always_comb begin
        gx_next = (ext(top_w[2]) + (ext(mid_w[2]) <<< 1) + ext(bot_w[2]))
                - (ext(top_w[0]) + (ext(mid_w[0]) <<< 1) + ext(bot_w[0]));
        gy_next = (ext(top_w[2]) + (ext(top_w[1]) <<< 1) + ext(top_w[0]))
                - (ext(bot_w[2]) + (ext(bot_w[1]) <<< 1) + ext(bot_w[0]));
    end

    // Border windows are forced to zero rather than saturated.
    always_comb begin
        abs_gx   = gx_r[GW-1] ? GW'(-gx_r) : GW'(gx_r);
        abs_gy   = gy_r[GW-1] ? GW'(-gy_r) : GW'(gy_r);
        mag      = {1'b0, abs_gx} + {1'b0, abs_gy};
        shifted  = mag >> SHIFT;
        pix_next = '0;
        if (!e2) begin
            pix_next = (shifted > SAT) ? '1 : shifted[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            top_w  <= '0;
            mid_w  <= '0;
            bot_w  <= '0;
            col    <= '0;
            v1     <= 1'b0;
            e1     <= 1'b0;
            gx_r   <= '0;
            gy_r   <= '0;
            v2     <= 1'b0;
            e2     <= 1'b0;
            oData  <= '0;
            oBin   <= 1'b0;
            oValid <= 1'b0;
            oEdge  <= 1'b0;
        end else if (enable) begin
            top_w <= {top_w[1:0], row_top};
            mid_w <= {mid_w[1:0], row_mid};
            bot_w <= {bot_w[1:0], row_bot};
            if (iValid) begin
                col <= col_last ? '0 : col + COL_W'(1);
            end else begin
                col <= '0;
            end
            v1     <= iValid;
            e1     <= iEdge | col_border | !iValid;
            gx_r   <= gx_next;
            gy_r   <= gy_next;
            v2     <= v1;
            e2     <= e1;
            oData  <= pix_next;
            oBin   <= (pix_next >= WIDTH'(THRESH));
            oValid <= v2;
            oEdge  <= e2;
        end
    end

endmodule

// File: tb/tb_sobel_window.sv
// Directed bench for sobel_window: vector table, stall replay, mid-line reset
// and a random 3-line wrap run against a behavioural Sobel model.
module tb_sobel_window;

    localparam int WIDTH    = 12;
    localparam int LINE_LEN = 8;
    localparam int SHIFT    = 2;
    localparam int THRESH   = 512;
    localparam int MAXV     = (1 << WIDTH) - 1;
    localparam int NRAND    = 3 * LINE_LEN;

    typedef struct packed {
        logic [WIDTH-1:0] top;
        logic [WIDTH-1:0] mid;
        logic [WIDTH-1:0] bot;
        logic             valid;
        logic             brd;
        logic [WIDTH-1:0] exp_data;
        logic             exp_bin;
        logic             exp_valid;
        logic             exp_edge;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             enable;
    logic             iValid;
    logic             iEdge;
    logic [WIDTH-1:0] row_top;
    logic [WIDTH-1:0] row_mid;
    logic [WIDTH-1:0] row_bot;
    logic [WIDTH-1:0] oData;
    logic             oBin;
    logic             oValid;
    logic             oEdge;

    int   checks = 0;
    int   passes = 0;
    vec_t tbl[$];
    vec_t zero_v = '0;

    int stepB[8]   = '{0, 0, 0, 100, 100, 100, 100, 100};
    int expB[8]    = '{0, 0, 0, 100, 100, 0, 0, 0};
    int threshD[8] = '{0, 0, 0, 512, 512, 1023, 1023, 1023};
    int expD[8]    = '{0, 0, 0, 512, 512, 511, 511, 0};
    int stepE[5]   = '{0, 0, 0, 100, 100};
    int expE[5]    = '{0, 0, 0, 0, 100};
    int pt[NRAND];
    int pm[NRAND];
    int pb[NRAND];

    sobel_window #(
        .WIDTH   (WIDTH),
        .LINE_LEN(LINE_LEN),
        .SHIFT   (SHIFT),
        .THRESH  (THRESH)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .iValid (iValid),
        .iEdge  (iEdge),
        .row_top(row_top),
        .row_mid(row_mid),
        .row_bot(row_bot),
        .oData  (oData),
        .oBin   (oBin),
        .oValid (oValid),
        .oEdge  (oEdge)
    );

    always #5 clk = ~clk;

    task automatic addVec(input int t, input int m, input int b, input logic v, input logic e,
                          input int d, input logic eb, input logic ev, input logic ee);
        vec_t x;
        x.top       = WIDTH'(t);
        x.mid       = WIDTH'(m);
        x.bot       = WIDTH'(b);
        x.valid     = v;
        x.brd       = e;
        x.exp_data  = WIDTH'(d);
        x.exp_bin   = eb;
        x.exp_valid = ev;
        x.exp_edge  = ee;
        tbl.push_back(x);
    endtask

    // Outputs seen after the k-th enabled vector belong to the window of vector k-2.
    function automatic vec_t expAt(input int k);
        if (k < 2) return zero_v;
        return tbl[k-2];
    endfunction

    function automatic vec_t modelExp(input int k);
        vec_t r;
        int   gx;
        int   gy;
        int   s;
        r = '0;
        r.exp_valid = 1'b1;
        if ((k % LINE_LEN) < 2) begin
            r.exp_edge = 1'b1;
            return r;
        end
        gx = (pt[k-2] + 2 * pm[k-2] + pb[k-2]) - (pt[k] + 2 * pm[k] + pb[k]);
        gy = (pt[k-2] + 2 * pt[k-1] + pt[k]) - (pb[k-2] + 2 * pb[k-1] + pb[k]);
        s  = ((gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy)) >> SHIFT;
        if (s > MAXV) s = MAXV;
        r.exp_data = WIDTH'(s);
        r.exp_bin  = (s >= THRESH);
        return r;
    endfunction

    task automatic applyStimulus(input vec_t v, input logic en);
        enable  = en;
        row_top = v.top;
        row_mid = v.mid;
        row_bot = v.bot;
        iValid  = v.valid;
        iEdge   = v.brd;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input vec_t e);
        checks++;
        if (oData === e.exp_data && oBin === e.exp_bin && oValid === e.exp_valid && oEdge === e.exp_edge) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got data=%0d bin=%0b valid=%0b edge=%0b, expected data=%0d bin=%0b valid=%0b edge=%0b",
                     name, oData, oBin, oValid, oEdge, e.exp_data, e.exp_bin, e.exp_valid, e.exp_edge);
        end
    endtask

    task automatic doReset();
        rst     = 1'b1;
        enable  = 1'b1;
        iValid  = 1'b0;
        iEdge   = 1'b0;
        row_top = '0;
        row_mid = '0;
        row_bot = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        // Line A: flat image
        for (int c = 0; c < 8; c++) addVec(800, 800, 800, 1, 0, 0, 0, 1, c < 2);
        // Line B: vertical step at column 3
        for (int c = 0; c < 8; c++) addVec(stepB[c], stepB[c], stepB[c], 1, 0, expB[c], 0, 1, c < 2);
        // Line C: strong Gx and Gy together, saturates from column 4
        for (int c = 0; c < 8; c++) addVec(4095, (c < 4) ? 4095 : 0, 0, 1, 0, (c < 2) ? 0 : 4095, c >= 2, 1, c < 2);
        // Line D: results straddling THRESH
        for (int c = 0; c < 8; c++) addVec(threshD[c], threshD[c], threshD[c], 1, 0, expD[c], expD[c] >= THRESH, 1, c < 2);
        // Line E: border flag on column 3, then valid drops
        for (int c = 0; c < 5; c++) addVec(stepE[c], stepE[c], stepE[c], 1, c == 3, expE[c], 0, 1, (c < 2) || (c == 3));
        for (int c = 0; c < 2; c++) addVec(0, 0, 0, 0, 0, 0, 0, 0, 1);
        // Line F: restart after the drop, column counter must be back at 0
        for (int c = 0; c < 3; c++) addVec(200, 200, 200, 1, 0, 0, 0, 1, c < 2);
        for (int c = 0; c < 2; c++) addVec(0, 0, 0, 0, 0, 0, 0, 0, 1);

        doReset();
        checkOutput("reset_state", zero_v);

        for (int j = 0; j < tbl.size(); j++) begin
            applyStimulus(tbl[j], 1'b1);
            checkOutput($sformatf("vec%0d", j), expAt(j));
        end

        // Replay lines A and B with random stalls and garbage inputs.
        doReset();
        for (int j = 0; j < 16; j++) begin
            int n;
            n = (j % 3 == 1) ? 2 : int'($urandom_range(0, 1));
            for (int s = 0; s < n; s++) begin
                enable  = 1'b0;
                row_top = WIDTH'($urandom_range(0, MAXV));
                row_mid = WIDTH'($urandom_range(0, MAXV));
                row_bot = WIDTH'($urandom_range(0, MAXV));
                iValid  = 1'($urandom_range(0, 1));
                iEdge   = 1'($urandom_range(0, 1));
                @(posedge clk);
                #1;
                checkOutput($sformatf("stall%0d_%0d", j, s), expAt(j - 1));
            end
            applyStimulus(tbl[j], 1'b1);
            checkOutput($sformatf("stall_vec%0d", j), expAt(j));
        end

        // Reset arriving at column 5 with enable low still clears everything.
        doReset();
        for (int j = 8; j < 13; j++) applyStimulus(tbl[j], 1'b1);
        checkOutput("pre_reset", tbl[10]);
        rst     = 1'b1;
        enable  = 1'b0;
        iValid  = 1'b1;
        row_top = 12'd777;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("mid_reset", zero_v);
        for (int k = 0; k < 5; k++) begin
            applyStimulus(tbl[k], 1'b1);
            checkOutput($sformatf("post_reset%0d", k), expAt(k));
        end

        // Three lines of random pixels across the column wrap.
        doReset();
        for (int i = 0; i < NRAND; i++) begin
            vec_t v;
            pt[i] = int'($urandom_range(0, MAXV) >> $urandom_range(0, 3));
            pm[i] = int'($urandom_range(0, MAXV) >> $urandom_range(0, 3));
            pb[i] = int'($urandom_range(0, MAXV) >> $urandom_range(0, 3));
            v = '0;
            v.top   = WIDTH'(pt[i]);
            v.mid   = WIDTH'(pm[i]);
            v.bot   = WIDTH'(pb[i]);
            v.valid = 1'b1;
            applyStimulus(v, 1'b1);
            checkOutput($sformatf("wrap%0d", i - 2), (i < 2) ? zero_v : modelExp(i - 2));
        end
        for (int i = NRAND; i < NRAND + 2; i++) begin
            applyStimulus(zero_v, 1'b1);
            checkOutput($sformatf("wrap%0d", i - 2), modelExp(i - 2));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
